// File: rtl/jtkcpu_busseq.sv
// Bus-cycle sequencer: splits one multi-byte request into byte cycles
// on the external bus, with dtack handshake, wait states, halt and timeout.
module jtkcpu_busseq #(
    parameter int AW    = 24,
    parameter int MAXB  = 4,
    parameter int WAITS = 0,
    parameter int TOUT  = 255
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              req,
    input  logic              req_we,
    input  logic [2:0]        req_len,
    input  logic [AW-1:0]     req_addr,
    input  logic [8*MAXB-1:0] wdata,
    output logic [8*MAXB-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              halt,
    input  logic              dtack,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [AW-1:0]     addr,
    output logic              we,
    output logic              as
);
    localparam int DW = 8*MAXB;
    localparam logic [2:0] MAXL = 3'(MAXB);
    localparam bit TOUT_EN = (TOUT != 0);
    localparam logic [15:0] TOUT_M1 = TOUT_EN ? 16'(TOUT - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} state_t;

    state_t          state, next;
    logic [2:0]      rem, len_c;
    logic [DW-1:0]   wbuf;
    logic [15:0]     wcnt, tcnt;
    logic            start, ack, tout, step;

    always_comb begin
        len_c = req_len;
        if (req_len == 3'd0)
            len_c = 3'd1;
        else if (req_len > MAXL)
            len_c = MAXL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (cen)
            state <= next;
    end

    always_comb begin
        next  = state;
        start = 1'b0;
        ack   = 1'b0;
        tout  = 1'b0;
        step  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && !halt) begin
                    start = 1'b1;
                    next  = ASSERT;
                end
            end
            ASSERT: begin
                // dtack only counts once the wait-state counter has run out
                if (wcnt == 16'd0) begin
                    if (dtack) begin
                        ack  = 1'b1;
                        next = RELEASE;
                    end else if (TOUT_EN && tcnt == TOUT_M1) begin
                        tout = 1'b1;
                        next = DONE;
                    end
                end
            end
            RELEASE: begin
                if (rem == 3'd0)
                    next = DONE;
                else if (!halt) begin
                    step = 1'b1;
                    next = ASSERT;
                end
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
        as   = (state == ASSERT);
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            addr  <= '0;
            dout  <= 8'd0;
            rdata <= '0;
            err   <= 1'b0;
            wbuf  <= '0;
            rem   <= 3'd0;
            wcnt  <= 16'd0;
            tcnt  <= 16'd0;
        end else if (cen) begin
            if (start) begin
                we    <= req_we;
                addr  <= req_addr;
                wbuf  <= wdata;
                rem   <= len_c;
                rdata <= '0;
                err   <= 1'b0;
                dout  <= wdata[8*32'(len_c - 3'd1) +: 8];
                wcnt  <= 16'(WAITS);
                tcnt  <= 16'd0;
            end
            if (state == ASSERT) begin
                if (wcnt != 16'd0)
                    wcnt <= wcnt - 16'd1;
                else if (!ack)
                    tcnt <= tcnt + 16'd1;
            end
            if (ack) begin
                rem <= rem - 3'd1;
                if (!we)
                    rdata <= (rdata << 8) | DW'(din);
            end
            if (tout)
                err <= 1'b1;
            // rem already counts the bytes still to go, so rem-1 is the next one
            if (step) begin
                addr <= addr + 1'b1;
                dout <= wbuf[8*32'(rem - 3'd1) +: 8];
                wcnt <= 16'(WAITS);
                tcnt <= 16'd0;
            end
        end
    end
endmodule

// File: tb/tb_jtkcpu_busseq.sv
// Bench for jtkcpu_busseq: table of requests with a byte/done scoreboard,
// plus sequences for halt, wait states, timeout and async reset.
module tb_jtkcpu_busseq;
    logic        clk = 1'b0;
    logic        rst, cen, req, s_we, halt, dtack;
    logic [2:0]  len;
    logic [23:0] s_addr;
    logic [31:0] wdata;
    logic [7:0]  din;

    logic [31:0] rdata0, rdata1;
    logic        busy0, done0, err0, we0, as0;
    logic        busy1, done1, err1, we1, as1;
    logic [7:0]  dout0, dout1;
    logic [23:0] addr0, addr1;

    int checks = 0;
    int errors = 0;
    int nbytes = 0;

    logic [7:0]  rd_bytes [4];
    logic [23:0] base;

    typedef struct {
        logic        we;
        logic [2:0]  len;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [31:0] exp_rdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic [23:0] addr;
        logic        we;
        logic [7:0]  dout;
    } bexp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } dexp_t;

    bexp_t qb[$];
    dexp_t qd[$];
    bexp_t me;
    dexp_t md;
    vec_t  vecs [6];

    always #5 clk = ~clk;

    always_comb din = rd_bytes[2'(addr0 - base)];

    jtkcpu_busseq dut0 (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .req_we(s_we),
        .req_len(len), .req_addr(s_addr), .wdata(wdata), .rdata(rdata0),
        .busy(busy0), .done(done0), .err(err0), .halt(halt),
        .dtack(dtack), .din(din), .dout(dout0), .addr(addr0),
        .we(we0), .as(as0)
    );

    jtkcpu_busseq #(.WAITS(2), .TOUT(8)) dut1 (
        .clk(clk), .rst(rst), .cen(cen), .req(req), .req_we(s_we),
        .req_len(len), .req_addr(s_addr), .wdata(wdata), .rdata(rdata1),
        .busy(busy1), .done(done1), .err(err1), .halt(halt),
        .dtack(dtack), .din(din), .dout(dout1), .addr(addr1),
        .we(we1), .as(as1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // byte cycles and done pulses of dut0 checked against the scoreboard
    always @(negedge clk) begin
        if (rst && cen) begin
            if (as0 && dtack) begin
                nbytes++;
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected: addr %h", addr0);
                end else begin
                    me = qb.pop_front();
                    if (addr0 !== me.addr || we0 !== me.we ||
                        (me.we && dout0 !== me.dout)) begin
                        errors++;
                        $display("FAIL byte: got a=%h we=%b d=%h expected a=%h we=%b d=%h",
                                 addr0, we0, dout0, me.addr, me.we, me.dout);
                    end
                end
            end
            if (done0) begin
                checks++;
                if (qd.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: rdata %h", rdata0);
                end else begin
                    md = qd.pop_front();
                    if (rdata0 !== md.rdata || err0 !== md.err) begin
                        errors++;
                        $display("FAIL done: got rdata=%h err=%b expected rdata=%h err=%b",
                                 rdata0, err0, md.rdata, md.err);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while ((busy0 || busy1) && n < 1000) begin
            tick;
            n++;
        end
        chk("idle", 32'(busy0 | busy1), 32'd0);
    endtask

    task automatic setup(input vec_t v, input logic perr);
        int le;
        le = (v.len == 3'd0) ? 1 : (v.len > 3'd4) ? 4 : int'(v.len);
        base = v.addr;
        for (int i = 0; i < 4; i++)
            rd_bytes[i] = v.rd[31-8*i -: 8];
        if (!perr)
            for (int i = 0; i < le; i++)
                qb.push_back('{v.addr + 24'(i), v.we,
                               v.we ? v.wdata[8*(le-1-i) +: 8] : 8'h00});
        qd.push_back('{v.exp_rdata, perr});
        s_we   = v.we;
        len    = v.len;
        s_addr = v.addr;
        wdata  = v.wdata;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        setup(v, 1'b0);
        req = 1'b1;
        tick;
        req = 1'b0;
        n = 1;
        while (!done0 && n < 64) begin
            tick;
            n++;
        end
        chk("latency", 32'(n), 32'(v.lat));
        wait_idle;
    endtask

    initial begin
        int cnt, pulses, n, nb;
        logic prev;
        vec_t v;

        vecs[0] = '{1'b0, 3'd2, 24'h00FFFF, 32'h0, 32'h1234_0000, 32'h0000_1234, 5};
        vecs[1] = '{1'b1, 3'd4, 24'hFFFFFE, 32'hDEADBEEF, 32'h0, 32'h0, 9};
        vecs[2] = '{1'b0, 3'd0, 24'h000100, 32'h0, 32'hA500_0000, 32'h0000_00A5, 3};
        vecs[3] = '{1'b0, 3'd7, 24'h123456, 32'h0, 32'h0102_0304, 32'h0102_0304, 9};
        vecs[4] = '{1'b1, 3'd1, 24'h000010, 32'h0000_00C3, 32'h0, 32'h0, 3};
        vecs[5] = '{1'b0, 3'd3, 24'hFFFFFF, 32'h0, 32'h1122_3300, 32'h0011_2233, 7};

        for (int i = 0; i < 4; i++) rd_bytes[i] = 8'h00;
        base = '0;
        rst = 1'b0; cen = 1'b1; req = 1'b0; s_we = 1'b0; halt = 1'b0;
        dtack = 1'b1; len = 3'd1; s_addr = '0; wdata = '0;
        tick; tick;
        chk("rst_outputs", {as0, busy0, done0, err0, we0, 3'b000, dout0, addr0[7:0], 8'h00},
            32'h0);
        chk("rst_addr_rdata", {8'h00, addr0} | rdata0, 32'h0);
        rst = 1'b1;
        tick;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // halt: held off in IDLE, then raised during byte 1 of a write
        v = '{1'b1, 3'd2, 24'h000200, 32'h0000_ABCD, 32'h0, 32'h0, 0};
        setup(v, 1'b0);
        halt = 1'b1;
        req  = 1'b1;
        tick; tick; tick;
        chk("halt_idle_busy", 32'(busy0), 32'd0);
        halt = 1'b0;
        tick;
        chk("halt_accept", {30'd0, busy0, as0}, 32'd3);
        req  = 1'b0;
        halt = 1'b1;
        nb   = nbytes;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("halt_as_low", 32'(as0), 32'd0);
        end
        chk("halt_one_byte", 32'(nbytes - nb), 32'd1);
        chk("halt_busy", 32'(busy0), 32'd1);
        halt = 1'b0;
        n = 0;
        while (!done0 && n < 20) begin
            tick;
            n++;
        end
        chk("halt_done", 32'(done0), 32'd1);
        wait_idle;

        // wait states, dtack already high: the first 2 samples are ignored
        v = '{1'b0, 3'd1, 24'h000400, 32'h0, 32'h5C00_0000, 32'h0000_005C, 0};
        setup(v, 1'b0);
        req = 1'b1;
        tick;
        req = 1'b0;
        cnt = 0; n = 0;
        while (!done1 && n < 40) begin
            if (as1) cnt++;
            tick;
            n++;
        end
        chk("waits_as_len", 32'(cnt), 32'd3);
        chk("waits_rdata", rdata1, 32'h5C);
        wait_idle;

        // wait states, dtack raised 3 cen after as rises
        v = '{1'b0, 3'd1, 24'h000410, 32'h0, 32'h9600_0000, 32'h0000_0096, 0};
        setup(v, 1'b0);
        dtack = 1'b0;
        req   = 1'b1;
        tick;
        req = 1'b0;
        cnt = 0; n = 0;
        while (!done1 && n < 40) begin
            if (as1) cnt++;
            if (as1 && cnt == 4) dtack = 1'b1;
            tick;
            n++;
        end
        chk("late_dtack_as_len", 32'(cnt), 32'd4);
        chk("late_dtack_rdata", rdata1, 32'h96);
        wait_idle;

        // timeout: dtack never comes
        v = '{1'b0, 3'd3, 24'h000300, 32'h0, 32'h0, 32'h0, 0};
        setup(v, 1'b1);
        dtack = 1'b0;
        req   = 1'b1;
        tick;
        req = 1'b0;
        cnt = 0; pulses = 0; prev = 1'b0; n = 0;
        while (!done1 && n < 40) begin
            if (as1) cnt++;
            if (as1 && !prev) pulses++;
            prev = as1;
            tick;
            n++;
        end
        chk("tout_done", 32'(done1), 32'd1);
        chk("tout_err", 32'(err1), 32'd1);
        chk("tout_as_len", 32'(cnt), 32'd10);
        chk("tout_pulses", 32'(pulses), 32'd1);
        chk("tout_rdata", rdata1, 32'h0);
        wait_idle;

        // async reset in the middle of a byte cycle with cen toggling
        s_we = 1'b1; len = 3'd4; s_addr = 24'h000500; wdata = 32'h01020304;
        req = 1'b1;
        tick;
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cen = ~cen;
            tick;
        end
        chk("pre_rst_as", {30'd0, as0, as1}, 32'd3);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_now_0", {29'd0, as0, busy0, done0}, 32'd0);
        chk("rst_now_1", {29'd0, as1, busy1, done1}, 32'd0);
        chk("rst_now_addr", {8'h00, addr0}, 32'd0);
        tick;
        rst = 1'b1; cen = 1'b1; dtack = 1'b1;
        tick;
        run_vec('{1'b1, 3'd2, 24'h000600, 32'h0000_7788, 32'h0, 32'h0, 5});

        chk("byte_queue_empty", 32'(qb.size()), 32'd0);
        chk("done_queue_empty", 32'(qd.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
